// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues fetch requests and registers
// the returned instruction (with its PC and a valid bit) for the decoder.
// Redirects flush the fetch register with a bubble; memory wait cycles
// insert one bubble per cycle; stall freezes the stage.
// Optional build macro: IF_FETCH_CNT_EN adds a free-running accepted-fetch
// counter on output fetch_cnt.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc;
  logic            accept;

  // A fetch completes only when memory answers and nothing higher-priority intervenes.
  assign accept    = !rst && !redirect && !stall && imem_ready;

  // Request and address are presented straight from the current PC.
  assign imem_req  = !rst && !stall;
  assign imem_addr = pc;

  // PC and fetch register update: rst > redirect > stall > accept > wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      inst       <= NOP_INST;
      inst_pc    <= RESET_PC;
      inst_valid <= 1'b0;
    end else if (redirect) begin
      pc         <= redirect_pc & ~XLEN'(3);
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
    end else if (stall) begin
      pc         <= pc;
    end else if (imem_ready) begin
      pc         <= pc + XLEN'(4);
      inst       <= imem_rdata;
      inst_pc    <= pc;
      inst_valid <= 1'b1;
    end else begin
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
    end
  end

`ifdef IF_FETCH_CNT_EN
  // Count accepted fetches; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
    end else if (accept) begin
      fetch_cnt <= fetch_cnt + XLEN'(1);
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming fetch, wait bubbles, stall,
// redirect with alignment and priority, PC wrap, reset mid-wait, and the
// optional fetch counter when IF_FETCH_CNT_EN is defined.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid)
`ifdef IF_FETCH_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Address-dependent instruction pattern served by the memory model.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  always_comb imem_rdata = pat(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b1;
    #1;
    tick(); tick();
    // Reset state
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_inst",  inst, NOP);
    chk("rst_ipc",   inst_pc, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_req",   32'(imem_req), 32'h0);

    // Streaming fetch with zero-wait memory
    rst = 1'b0; #1;
    chk("run_req", 32'(imem_req), 32'h1);
    tick();
    chk("s0_inst",  inst, pat(32'h0));
    chk("s0_ipc",   inst_pc, 32'h0);
    chk("s0_valid", 32'(inst_valid), 32'h1);
    chk("s0_addr",  imem_addr, 32'h4);
    tick();
    chk("s1_inst", inst, pat(32'h4));
    chk("s1_ipc",  inst_pc, 32'h4);
    chk("s1_addr", imem_addr, 32'h8);
    tick(); tick();
    chk("s3_ipc",  inst_pc, 32'hC);
    chk("s3_addr", imem_addr, 32'h10);

    // Three wait cycles at 0x10
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w_addr",  imem_addr, 32'h10);
      chk("w_inst",  inst, NOP);
      chk("w_valid", 32'(inst_valid), 32'h0);
    end
    imem_ready = 1'b1;
    tick();
    chk("w_done_inst",  inst, pat(32'h10));
    chk("w_done_ipc",   inst_pc, 32'h10);
    chk("w_done_valid", 32'(inst_valid), 32'h1);
    chk("w_done_addr",  imem_addr, 32'h14);

    // Reposition to inst_pc=0x8, pc=0xC, then stall two cycles
    redirect = 1'b1; redirect_pc = 32'h8;
    tick();
    chk("rd8_addr",  imem_addr, 32'h8);
    chk("rd8_valid", 32'(inst_valid), 32'h0);
    redirect = 1'b0;
    tick();
    chk("pre_st_ipc", inst_pc, 32'h8);
    stall = 1'b1; #1;
    chk("st_req", 32'(imem_req), 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st_inst",  inst, pat(32'h8));
      chk("st_ipc",   inst_pc, 32'h8);
      chk("st_addr",  imem_addr, 32'hC);
      chk("st_valid", 32'(inst_valid), 32'h1);
    end
    stall = 1'b0;
    tick();
    chk("st_res_ipc",  inst_pc, 32'hC);
    chk("st_res_inst", inst, pat(32'hC));
    chk("st_res_addr", imem_addr, 32'h10);

    // Redirect beats stall and ready; target is word-aligned
    redirect = 1'b1; redirect_pc = 32'h103; stall = 1'b1; imem_ready = 1'b1;
    tick();
    chk("rdp_addr",  imem_addr, 32'h100);
    chk("rdp_valid", 32'(inst_valid), 32'h0);
    chk("rdp_inst",  inst, NOP);
    redirect = 1'b0; stall = 1'b0;
    tick();
    chk("rdp_f_ipc",  inst_pc, 32'h100);
    chk("rdp_f_inst", inst, pat(32'h100));
    chk("rdp_f_addr", imem_addr, 32'h104);

    // PC wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    chk("wrap_ipc",  inst_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset in the middle of a wait
    imem_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rw_addr",  imem_addr, 32'h0);
    chk("rw_ipc",   inst_pc, 32'h0);
    chk("rw_valid", 32'(inst_valid), 32'h0);
    chk("rw_inst",  inst, NOP);

`ifdef IF_FETCH_CNT_EN
    // Counter: 5 accepts, 2 waits, 1 redirect -> 5; reset clears
    chk("cnt_rst", fetch_cnt, 32'h0);
    rst = 1'b0; imem_ready = 1'b1;
    tick(); tick(); tick();
    imem_ready = 1'b0;
    tick(); tick();
    imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    tick(); tick();
    chk("cnt_5", fetch_cnt, 32'd5);
    rst = 1'b1;
    tick();
    chk("cnt_clr", fetch_cnt, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
